// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the regfile write port.
// Arbitrates ALU vs LSU results with ALU anti-starvation.
module writeback_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [31:0]      lsu_data,
  output logic [4:0]       rd,
  output logic [31:0]      regdata,
  output logic             wer,
  output logic [CNT_W-1:0] wb_count
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  logic [3:0]  alu_wait;
  logic        starve;
  logic        grant;
  logic [4:0]  g_rd;
  logic [31:0] g_data;
  logic        we_nxt;

  assign starve = (alu_wait >= WMAX);

  // Grant selection: LSU preferred unless ALU has starved.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!flush) begin
      if (alu_valid && (!lsu_valid || starve))
        alu_ready = 1'b1;
      else if (lsu_valid)
        lsu_ready = 1'b1;
    end
  end

  assign grant  = alu_ready | lsu_ready;
  assign g_rd   = alu_ready ? alu_rd : lsu_rd;
  assign g_data = alu_ready ? alu_data : lsu_data;
  assign we_nxt = grant && (g_rd != 5'd0);

  // Count cycles a pending ALU result loses arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alu_wait <= 4'd0;
    else if (flush || !alu_valid || alu_ready)
      alu_wait <= 4'd0;
    else if (alu_wait < WMAX)
      alu_wait <= alu_wait + 4'd1;
  end

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd      <= 5'd0;
      regdata <= 32'd0;
      wer     <= 1'b0;
    end else begin
      wer <= we_nxt;
      if (grant) begin
        rd      <= g_rd;
        regdata <= g_data;
      end
    end
  end

  // Retired-write counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_count <= '0;
    else if (we_nxt)
      wb_count <= wb_count + CNT_W'(1);
  end

endmodule
